debounce_multi: RTL and testbench

Parametrised N-channel push-button/switch debouncer, the successor to the single-channel debouncer. Each channel has a two-flop synchroniser, a per-channel polarity select, and a stability counter clocked by a shared prescaler tick. Outputs are registered level state plus one-cycle press/release pulses. Used in front of MCU GPIO/interrupt logic for keypads and board buttons.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_multi_if.sv | 31 +++
 rtl/debounce_chan.sv | 140 ++++++++++++++
 rtl/debounce_multi.sv | 74 +++++++
 tb/tb_debounce_multi.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults, widths and types for the multi-channel debouncer
package debounce_pkg;

  localparam int DEF_DELAY        = 16;
  localparam int DEF_PRESCALE     = 0;
  localparam int DEF_REPEAT_DELAY = 8;
  localparam int DEF_REPEAT_RATE  = 2;

  // Repeat counter counts whole threshold periods, so REPEAT_DELAY/RATE must fit in it.
  localparam int REP_W = 8;

  typedef enum logic {
    REP_HOLD,
    REP_RUN
  } rep_state_t;

endpackage

// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - raw button inputs and debounced level/event outputs
interface debounce_multi_if #(
  parameter int N = 4
);

  logic [N-1:0] PB;
  logic [N-1:0] PB_state;
  logic [N-1:0] PB_down;
  logic [N-1:0] PB_up;
  logic [N-1:0] PB_repeat;
  logic         PB_any;

  modport master (
    output PB,
    input  PB_state,
    input  PB_down,
    input  PB_up,
    input  PB_repeat,
    input  PB_any
  );

  modport slave (
    input  PB,
    output PB_state,
    output PB_down,
    output PB_up,
    output PB_repeat,
    output PB_any
  );

endinterface

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, stability counter, level and pulses
// Auto-repeat generator is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DELAY        = DEF_DELAY,
  parameter bit INV          = 1'b1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic CLK,
  input  logic RST,
  input  logic pb,
  input  logic tick,
  output logic state,
  output logic down,
  output logic up,
  output logic rpt,
  output logic event_nxt
);

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      REPEAT_DELAY > 2**REP_W || REPEAT_RATE > 2**REP_W) begin : g_bad_repeat_cfg
    $error("debounce_chan: REPEAT_DELAY/REPEAT_RATE out of range");
  end

  logic             sync0;
  logic             sync1;
  logic [DELAY-1:0] cnt;
  logic             idle;
  logic             fire;
  logic             down_nxt;
  logic             up_nxt;
  logic             rpt_nxt;

  assign idle     = (state == sync1);
  assign fire     = !idle && tick && (&cnt);
  assign down_nxt = fire && !state;
  assign up_nxt   = fire && state;
  assign event_nxt = down_nxt | up_nxt | rpt_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= pb ^ INV;
      sync1 <= sync0;
    end
  end

  // Any cycle that agrees with the accepted level restarts the stability count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (idle) begin
      cnt <= '0;
    end else if (tick) begin
      if (&cnt) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DELAY'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      down <= 1'b0;
      up   <= 1'b0;
    end else begin
      down <= down_nxt;
      up   <= up_nxt;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [REP_W-1:0] FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  rep_state_t       rep_q;
  rep_state_t       rep_d;
  logic [DELAY-1:0] per_q;
  logic [DELAY-1:0] per_d;
  logic [REP_W-1:0] rcnt_q;
  logic [REP_W-1:0] rcnt_d;
  logic             period_done;
  logic             rpt_q;

  assign period_done = tick && (&per_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_q  <= REP_HOLD;
      per_q  <= '0;
      rcnt_q <= '0;
      rpt_q  <= 1'b0;
    end else begin
      rep_q  <= rep_d;
      per_q  <= per_d;
      rcnt_q <= rcnt_d;
      rpt_q  <= rpt_nxt;
    end
  end

  // A press edge always happens while state is still 0, so clearing on !state covers it.
  always_comb begin
    rep_d   = rep_q;
    per_d   = per_q;
    rcnt_d  = rcnt_q;
    rpt_nxt = 1'b0;
    if (!state) begin
      rep_d  = REP_HOLD;
      per_d  = '0;
      rcnt_d = '0;
    end else begin
      if (tick) begin
        per_d = per_q + DELAY'(1);
      end
      if (period_done) begin
        if (rcnt_q == ((rep_q == REP_RUN) ? RATE_LAST : FIRST_LAST)) begin
          rpt_nxt = 1'b1;
          rcnt_d  = '0;
          rep_d   = REP_RUN;
        end else begin
          rcnt_d = rcnt_q + REP_W'(1);
        end
      end
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt_nxt = 1'b0;
  assign rpt     = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel debouncer top: shared prescaler, channels, PB_any register
// PB_repeat is generated only when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int           N            = 4,
  parameter int           DELAY        = DEF_DELAY,
  parameter int           PRESCALE     = DEF_PRESCALE,
  parameter logic [N-1:0] INVERT       = {N{1'b1}},
  parameter int           REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int           REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic           CLK,
  input  logic           RST,
  debounce_multi_if.slave bus
);

  logic         tick;
  logic [N-1:0] ev_nxt;
  logic [N-1:0] state_v;
  logic [N-1:0] down_v;
  logic [N-1:0] up_v;
  logic [N-1:0] rpt_v;

  if (PRESCALE == 0) begin : g_no_pre
    assign tick = 1'b1;
  end else begin : g_pre
    logic [PRESCALE-1:0] pre;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        pre <= '0;
      end else begin
        pre <= pre + PRESCALE'(1);
      end
    end

    assign tick = &pre;
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .DELAY        (DELAY),
      .INV          (INVERT[i]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .CLK       (CLK),
      .RST       (RST),
      .pb        (bus.PB[i]),
      .tick      (tick),
      .state     (state_v[i]),
      .down      (down_v[i]),
      .up        (up_v[i]),
      .rpt       (rpt_v[i]),
      .event_nxt (ev_nxt[i])
    );
  end

  assign bus.PB_state  = state_v;
  assign bus.PB_down   = down_v;
  assign bus.PB_up     = up_v;
  assign bus.PB_repeat = rpt_v;

  // Built from the channels' next-pulse terms so it lines up with the registered pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.PB_any <= 1'b0;
    end else begin
      bus.PB_any <= |ev_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi (fast config and prescaled config)
module tb_debounce_multi;

  typedef struct {
    int         cyc;
    logic [3:0] down;
    logic [3:0] up;
    logic [3:0] rpt;
    logic [3:0] state;
  } ev_t;

  logic CLK  = 1'b0;
  logic RST  = 1'b1;
  logic rst2 = 1'b1;
  int   cyc  = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  q1[$];
  ev_t  q2[$];
  ev_t  e1;
  ev_t  e2;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  debounce_multi_if #(.N(4)) bus1 ();
  debounce_multi_if #(.N(4)) bus2 ();

  debounce_multi #(
    .N(4), .DELAY(4), .PRESCALE(0), .INVERT(4'hF), .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1)
  );

  debounce_multi #(
    .N(4), .DELAY(2), .PRESCALE(2), .INVERT(4'hF), .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut2 (
    .CLK (CLK),
    .RST (rst2),
    .bus (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push1(input int c, input logic [3:0] d, input logic [3:0] u,
                       input logic [3:0] r, input logic [3:0] s);
    ev_t e;
    e.cyc = c; e.down = d; e.up = u; e.rpt = r; e.state = s;
    q1.push_back(e);
  endtask

  task automatic push2(input int c, input logic [3:0] d, input logic [3:0] u,
                       input logic [3:0] r, input logic [3:0] s);
    ev_t e;
    e.cyc = c; e.down = d; e.up = u; e.rpt = r; e.state = s;
    q2.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (bus1.PB_any || (|bus1.PB_down) || (|bus1.PB_up) || (|bus1.PB_repeat)) begin
      if (q1.size() == 0) begin
        chk("d1_unexpected_event", {bus1.PB_down, bus1.PB_up, bus1.PB_repeat, bus1.PB_any}, 0);
      end else begin
        e1 = q1.pop_front();
        chk("d1_event_cycle", cyc, e1.cyc);
        chk("d1_down", bus1.PB_down, e1.down);
        chk("d1_up", bus1.PB_up, e1.up);
        chk("d1_repeat", bus1.PB_repeat, e1.rpt);
        chk("d1_state", bus1.PB_state, e1.state);
        chk("d1_any", bus1.PB_any, 1);
      end
    end
  end

  always @(negedge CLK) begin
    if (bus2.PB_any || (|bus2.PB_down) || (|bus2.PB_up) || (|bus2.PB_repeat)) begin
      if (q2.size() == 0) begin
        chk("d2_unexpected_event", {bus2.PB_down, bus2.PB_up, bus2.PB_repeat, bus2.PB_any}, 0);
      end else begin
        e2 = q2.pop_front();
        chk("d2_event_cycle", cyc, e2.cyc);
        chk("d2_down", bus2.PB_down, e2.down);
        chk("d2_up", bus2.PB_up, e2.up);
        chk("d2_repeat", bus2.PB_repeat, e2.rpt);
        chk("d2_state", bus2.PB_state, e2.state);
        chk("d2_any", bus2.PB_any, 1);
      end
    end
  end

  initial begin
    int c;
    int c0;
    int glitch_len[2];
    glitch_len[0] = 10;
    glitch_len[1] = 15;
    bus1.PB = 4'hF;
    bus2.PB = 4'hF;

    // Reset values
    wait_cyc(3);
    chk("rst_state", bus1.PB_state, 0);
    chk("rst_down", bus1.PB_down, 0);
    chk("rst_up", bus1.PB_up, 0);
    chk("rst_repeat", bus1.PB_repeat, 0);
    chk("rst_any", bus1.PB_any, 0);
    chk("rst_state_d2", bus2.PB_state, 0);
    RST  = 1'b0;
    rst2 = 1'b0;
    c0   = cyc;
    wait_cyc(5);
    chk("idle_state", bus1.PB_state, 0);

    // Press ch0: sampled on the next edge, accepted 18 edges after it was driven
    c = cyc;
    bus1.PB[0] = 1'b0;
    push1(c + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(30);

    // Glitches on ch1 of 10 and 15 cycles (15 is one short of acceptance)
    for (int i = 0; i < 2; i++) begin
      bus1.PB[1] = 1'b0;
      wait_cyc(glitch_len[i]);
      bus1.PB[1] = 1'b1;
      wait_cyc(30);
      chk("glitch_state", bus1.PB_state, 4'b0001);
    end

    // Release ch0
    c = cyc;
    bus1.PB[0] = 1'b1;
    push1(c + 18, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(30);

    // Simultaneous press of ch2 and ch3, then release ch2 only
    c = cyc;
    bus1.PB[3:2] = 2'b00;
    push1(c + 18, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
    wait_cyc(30);
    c = cyc;
    bus1.PB[2] = 1'b1;
    push1(c + 18, 4'b0000, 4'b0100, 4'b0000, 4'b1000);
    wait_cyc(30);

    // Mid-count reset with ch3 held and ch0 counting: async clear, no pulse, fresh count
    bus1.PB[0] = 1'b0;
    wait_cyc(12);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_state", bus1.PB_state, 0);
    chk("async_rst_down", bus1.PB_down, 0);
    chk("async_rst_any", bus1.PB_any, 0);
    wait_cyc(3);
    RST = 1'b0;
    c = cyc;
    push1(c + 18, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    wait_cyc(30);
    c = cyc;
    bus1.PB[0] = 1'b1;
    bus1.PB[3] = 1'b1;
    push1(c + 18, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    wait_cyc(30);
    chk("final_state_d1", bus1.PB_state, 0);

    // Prescaled channel: drive so that two edges later is a prescaler tick edge
    while (((cyc + 2 - c0) % 4) != 0) @(negedge CLK);
    c = cyc;
    bus2.PB[0] = 1'b0;
    push2(c + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef DEBOUNCE_REPEAT_EN
    push2(c + 50, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push2(c + 66, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push2(c + 82, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    wait_cyc(76);
    bus2.PB[0] = 1'b1;
    push2(c + 94, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(60);
    chk("final_state_d2", bus2.PB_state, 0);

    while (q1.size() != 0) begin
      e1 = q1.pop_front();
      chk("d1_missing_event_cyc", 0, e1.cyc);
    end
    while (q2.size() != 0) begin
      e2 = q2.pop_front();
      chk("d2_missing_event_cyc", 0, e2.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
